// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port owner: the loader writes the image, then the controller
// streams sequential fetches with a one-entry skid buffer and redirect squash.
module imem_fetch_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              fetch_stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);

    typedef enum logic {
        LOAD,
        FETCH
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [ADDR_W-1:0] skid_pc;
    logic              issue;
    logic              consume;
    logic              fetch_live;
    logic              ret_to_out;
    logic              ret_to_skid;

    // The returning word bypasses the skid whenever the output slot is free or draining.
    assign fetch_live  = (state == FETCH) && !redirect_valid;
    assign consume     = inst_valid && !fetch_stall;
    assign ret_to_out  = fetch_live && inflight && (!inst_valid || !fetch_stall);
    assign ret_to_skid = fetch_live && inflight && inst_valid && fetch_stall;

    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc;
        mem_wdata = '0;
        issue     = 1'b0;
        case (state)
            LOAD: begin
                ld_ready  = 1'b1;
                mem_en    = ld_valid;
                mem_we    = ld_valid;
                mem_addr  = ld_addr;
                mem_wdata = ld_data;
                if (ld_done) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                issue    = !fetch_stall && !skid_valid && !redirect_valid;
                mem_en   = issue;
                mem_addr = pc;
            end
        endcase
    end

    // Control and output registers: reset clears everything, including a pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            pc         <= START_PC;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                if (ld_done) begin
                    pc <= START_PC;
                end
                inflight   <= 1'b0;
                skid_valid <= 1'b0;
                inst_valid <= 1'b0;
            end else if (redirect_valid) begin
                pc         <= redirect_pc;
                inflight   <= 1'b0;
                skid_valid <= 1'b0;
                inst_valid <= 1'b0;
            end else begin
                if (issue) begin
                    pc <= pc + ADDR_W'(1);
                end
                inflight <= issue;
                if (ret_to_out) begin
                    inst_valid <= 1'b1;
                    inst       <= mem_rdata;
                    inst_pc    <= inflight_pc;
                end else if (ret_to_skid) begin
                    skid_valid <= 1'b1;
                end else if (consume) begin
                    if (skid_valid) begin
                        inst       <= skid_data;
                        inst_pc    <= skid_pc;
                        skid_valid <= 1'b0;
                    end else begin
                        inst_valid <= 1'b0;
                    end
                end
            end
        end
    end

    // Data-only registers; their contents are qualified by inflight / skid_valid.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc <= pc;
        end
        if (ret_to_skid) begin
            skid_data <= mem_rdata;
            skid_pc   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a behavioural 1-cycle-latency memory,
// directed load/fetch/stall/redirect/reset sequences, and a monitor on consumed instructions.
module tb_imem_fetch_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              fetch_stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .ld_done       (ld_done),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .fetch_stall   (fetch_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc)
    );

    logic [DATA_W-1:0] mem   [32];
    logic [DATA_W-1:0] image [32];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: every consumed instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && inst_valid && !fetch_stall) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_extra actual pc=%0d data=%h required none", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.data) begin
                    bad++;
                    $display("FAIL stream actual pc=%0d data=%h required pc=%0d data=%h",
                             inst_pc, inst, e.pc, e.data);
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_range(input int start, input int n);
        logic [ADDR_W-1:0] p;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            p = ADDR_W'(start + i);
            e.pc   = p;
            e.data = image[p];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_pc(input int p);
        logic found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            mid();
            if (inst_valid && inst_pc == ADDR_W'(p)) found = 1'b1;
        end
        chk("wait_pc_reached", 32'(found), 1);
    endtask

    // Redirect in the current cycle; target must show 3 cycles later.
    task automatic do_redirect(input int target, input logic stall, input int shown);
        redirect_valid = 1'b1;
        redirect_pc    = ADDR_W'(target);
        fetch_stall    = stall;
        mid();
        chk("redir_shown_valid", 32'(inst_valid), 1);
        chk("redir_shown_pc", 32'(inst_pc), shown);
        chk("redir_no_issue", 32'(mem_en), 0);
        next();
        redirect_valid = 1'b0;
        fetch_stall    = 1'b0;
        mid();
        chk("redir_squash_t1", 32'(inst_valid), 0);
        chk("redir_first_read", 32'(mem_addr), target);
        next();
        mid();
        chk("redir_squash_t2", 32'(inst_valid), 0);
        next();
        mid();
        chk("redir_t3_valid", 32'(inst_valid), 1);
        chk("redir_t3_pc", 32'(inst_pc), target);
        chk("redir_t3_inst", inst, image[target]);
        next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        fetch_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        next();
        next();
        mid();
        chk("rst_ld_ready", 32'(ld_ready), 1);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", 32'(inst_pc), 0);
        next();
        rst = 1'b0;

        // Load the image; a redirect during load must be ignored.
        for (int k = 0; k < 32; k++) begin
            ld_valid = 1'b1;
            ld_addr  = ADDR_W'(k);
            ld_data  = 32'hA000_0000 + 32'(k);
            image[k] = 32'hA000_0000 + 32'(k);
            redirect_valid = (k == 7);
            redirect_pc    = 5'd17;
            mid();
            chk("load_ready", 32'(ld_ready), 1);
            chk("load_we", 32'(mem_we), 1);
            chk("load_addr", 32'(mem_addr), k);
            next();
        end
        ld_valid = 1'b0; redirect_valid = 1'b0; ld_done = 1'b1;
        push_range(0, 32);
        push_range(0, 10);
        mid();
        chk("done_ready", 32'(ld_ready), 1);
        chk("done_inst_valid", 32'(inst_valid), 0);
        next();

        // First fetch cycle; loader requests are ignored now.
        ld_done = 1'b0; ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'hFFFF_FFFF;
        mid();
        chk("f1_inst_valid", 32'(inst_valid), 0);
        chk("f1_mem_en", 32'(mem_en), 1);
        chk("f1_mem_we", 32'(mem_we), 0);
        chk("f1_mem_addr", 32'(mem_addr), 0);
        chk("f1_mem_wdata", mem_wdata, 0);
        chk("f1_ld_ready", 32'(ld_ready), 0);
        next();
        ld_valid = 1'b0;
        mid();
        chk("f2_inst_valid", 32'(inst_valid), 0);
        next();
        mid();
        chk("f3_inst_valid", 32'(inst_valid), 1);
        chk("f3_inst_pc", 32'(inst_pc), 0);
        chk("f3_inst", inst, 32'hA000_0000);
        next();

        // Through the wrap, then stall with pc 5 showing.
        wait_pc(31);
        wait_pc(4);
        next();
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("stall_valid", 32'(inst_valid), 1);
            chk("stall_pc", 32'(inst_pc), 5);
            chk("stall_inst", inst, image[5]);
            chk("stall_mem_en", 32'(mem_en), 0);
            next();
        end
        fetch_stall = 1'b0;

        // Redirect with stall: output pc 10 and in-flight pc 11 both dropped.
        wait_pc(9);
        next();
        push_range(20, 12);
        push_range(0, 10);
        do_redirect(20, 1'b1, 10);

        // Redirect without stall: pc 9 consumed, in-flight pc 10 dropped.
        wait_pc(8);
        next();
        push_range(20, 3);
        do_redirect(20, 1'b0, 9);

        // Reset mid-fetch.
        wait_pc(22);
        next();
        rst = 1'b1;
        next();
        mid();
        chk("mrst_inst_valid", 32'(inst_valid), 0);
        chk("mrst_mem_en", 32'(mem_en), 0);
        chk("mrst_ld_ready", 32'(ld_ready), 1);
        chk("mrst_inst_pc", 32'(inst_pc), 0);
        chk("mrst_queue_empty", 32'(exp_q.size()), 0);
        next();
        rst = 1'b0;

        // Write and done in the same cycle.
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'hDEAD_BEEF; ld_done = 1'b1;
        image[3] = 32'hDEAD_BEEF;
        push_range(0, 7);
        push_range(3, 2);
        mid();
        chk("edge_ready", 32'(ld_ready), 1);
        chk("edge_mem_en", 32'(mem_en), 1);
        chk("edge_mem_we", 32'(mem_we), 1);
        chk("edge_mem_addr", 32'(mem_addr), 3);
        chk("edge_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        next();
        ld_valid = 1'b0; ld_done = 1'b0;
        mid();
        chk("edge_f1_valid", 32'(inst_valid), 0);
        chk("edge_f1_mem_en", 32'(mem_en), 1);
        chk("edge_f1_addr", 32'(mem_addr), 0);
        next();
        mid();
        chk("edge_f2_valid", 32'(inst_valid), 0);
        next();
        mid();
        chk("edge_f3_valid", 32'(inst_valid), 1);
        chk("edge_f3_pc", 32'(inst_pc), 0);
        next();
        wait_pc(5);
        next();
        do_redirect(3, 1'b0, 6);
        wait_pc(4);
        next();
        rst = 1'b1;
        next();
        mid();
        chk("end_queue_empty", 32'(exp_q.size()), 0);
        chk("end_inst_valid", 32'(inst_valid), 0);
        next();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
